// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, widths and writeback source selection.
package mips_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;

  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_JAL = 6'h03;

  typedef enum logic [1:0] {
    WB_SEL_ALU,
    WB_SEL_MEM,
    WB_SEL_LINK
  } wb_sel_e;

  function automatic wb_sel_e wb_sel_of(input logic [5:0] opcode);
    case (opcode)
      OPC_LW:  return WB_SEL_MEM;
      OPC_JAL: return WB_SEL_LINK;
      default: return WB_SEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: one write port, two combinational read ports
// with register-zero masking and same-cycle write bypass.
module reg_file #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_num_a,
  input  logic [IDX_W-1:0]  rd_num_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_live;

  // Entry 0 exists but is never written, so it stays at its reset value.
  assign wr_live = wr_en && (wr_num != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_num] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] num);
    if (num == '0)
      return '0;
    else if (wr_live && (wr_num == num))
      return wr_data;
    else
      return regs[num];
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_num_a);
    rd_data_b = read_port(rd_num_b);
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value by opcode, commits it to the
// register file, exports it for forwarding and counts committed writes.
module wb_regfile #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_reg_mm_wb,
  input  logic [IDX_W-1:0]  wr_num_mm_wb,
  input  logic [5:0]        opcode_mm_wb,
  input  logic [DATA_W-1:0] pc_mm_wb,
  input  logic [DATA_W-1:0] data_out_alu_wb,
  input  logic [DATA_W-1:0] data_out_mem_wb,
  input  logic [IDX_W-1:0]  rd_num_a,
  input  logic [IDX_W-1:0]  rd_num_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_wr_en,
  output logic [IDX_W-1:0]  wb_wr_num,
  output logic [31:0]       wr_count
);

  import mips_pkg::*;

  logic [31:0] wr_count_q;

  always_comb begin
    wb_data = data_out_alu_wb;
    case (wb_sel_of(opcode_mm_wb))
      WB_SEL_MEM:  wb_data = data_out_mem_wb;
      WB_SEL_LINK: wb_data = pc_mm_wb + DATA_W'(4);
      default:     wb_data = data_out_alu_wb;
    endcase
  end

  assign wb_wr_en  = wr_en_reg_mm_wb && (wr_num_mm_wb != '0);
  assign wb_wr_num = wr_num_mm_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_count_q <= '0;
    else if (wb_wr_en)
      wr_count_q <= wr_count_q + 32'd1;
  end

  assign wr_count = wr_count_q;

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wb_wr_en),
    .wr_num    (wr_num_mm_wb),
    .wr_data   (wb_data),
    .rd_num_a  (rd_num_a),
    .rd_num_b  (rd_num_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: committed writes are queued and read back.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_num;
  logic [5:0]  opc;
  logic [31:0] pc, alu, mem;
  logic [4:0]  ra, rb;
  logic [31:0] rd_a, rd_b, wb_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_num;
  logic [31:0] wr_count;

  logic [31:0] mregs [32];
  logic [31:0] mcount;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } sb_t;
  sb_t sbq [$];

  wb_regfile #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en_reg_mm_wb (wr_en),
    .wr_num_mm_wb    (wr_num),
    .opcode_mm_wb    (opc),
    .pc_mm_wb        (pc),
    .data_out_alu_wb (alu),
    .data_out_mem_wb (mem),
    .rd_num_a        (ra),
    .rd_num_b        (rb),
    .rd_data_a       (rd_a),
    .rd_data_b       (rd_b),
    .wb_data         (wb_data),
    .wb_wr_en        (wb_wr_en),
    .wb_wr_num       (wb_wr_num),
    .wr_count        (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb(input logic [5:0] o, input logic [31:0] a,
                                         input logic [31:0] m, input logic [31:0] p);
    if (o == 6'h23)      return m;
    else if (o == 6'h03) return p + 32'd4;
    else                 return a;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] r, input logic een,
                                         input logic [4:0] n, input logic [31:0] v);
    if (r == 5'd0)            return 32'h0;
    else if (een && n == r)   return v;
    else                      return mregs[r];
  endfunction

  // One writeback cycle: check the combinational outputs, then commit.
  task automatic drive_wb(input logic en, input logic [4:0] num, input logic [5:0] o,
                          input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                          input logic [4:0] r_a, input logic [4:0] r_b);
    logic [31:0] ewb;
    logic        een;
    @(negedge clk);
    wr_en = en; wr_num = num; opc = o; alu = a; mem = m; pc = p; ra = r_a; rb = r_b;
    #1;
    ewb = exp_wb(o, a, m, p);
    een = en && (num != 5'd0);
    check_eq("wb_data", wb_data, ewb);
    check_eq("wb_wr_en", {31'h0, wb_wr_en}, {31'h0, een});
    check_eq("wb_wr_num", {27'h0, wb_wr_num}, {27'h0, num});
    check_eq("rd_a_bypass", rd_a, exp_rd(r_a, een, num, ewb));
    check_eq("rd_b_bypass", rd_b, exp_rd(r_b, een, num, ewb));
    if (een) sbq.push_back('{idx: num, val: ewb});
    @(posedge clk);
    if (een) begin
      mregs[num] = ewb;
      mcount     = mcount + 32'd1;
    end
    #1;
    check_eq("wr_count", wr_count, mcount);
  endtask

  task automatic drain;
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      wr_en = 1'b0; ra = e.idx; rb = e.idx;
      #1;
      check_eq($sformatf("reg%0d_a", e.idx), rd_a, e.val);
      check_eq($sformatf("reg%0d_b", e.idx), rd_b, e.val);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcount = 32'h0;
    sbq.delete();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_num = '0; opc = '0; pc = '0; alu = '0; mem = '0;
    ra = 5'd5; rb = 5'd31;
    #1;
    check_eq("rst_count", wr_count, 32'h0);
    check_eq("rst_rd_a", rd_a, 32'h0);
    check_eq("rst_rd_b", rd_b, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU writeback with bypass, then stored readback
    drive_wb(1'b1, 5'd5, 6'h00, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 5'd0);
    drain();
    check_eq("count_after_alu", wr_count, 32'd1);

    // load and JAL selection, including PC wrap
    drive_wb(1'b1, 5'd8,  6'h23, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd5);
    drive_wb(1'b1, 5'd31, 6'h03, 32'h0, 32'h0, 32'h0040_0010, 5'd31, 5'd8);
    drive_wb(1'b1, 5'd30, 6'h03, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd30, 5'd31);
    drain();

    // register zero protection
    drive_wb(1'b1, 5'd0, 6'h00, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk); wr_en = 1'b0; ra = 5'd0; rb = 5'd0; #1;
    check_eq("r0_next_a", rd_a, 32'h0);
    check_eq("r0_count", wr_count, mcount);

    // dual-port bypass and an untouched neighbour
    drive_wb(1'b1, 5'd9, 6'h00, 32'h0909_0909, 32'h0, 32'h0, 5'd9, 5'd0);
    drive_wb(1'b1, 5'd7, 6'h00, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd7, 5'd7);
    drive_wb(1'b1, 5'd10, 6'h23, 32'h0, 32'h1111_2222, 32'h0, 5'd9, 5'd7);
    drain();

    // disabled write with an undefined opcode changes nothing
    @(negedge clk); wr_en = 1'b0; wr_num = 5'd9; opc = 6'bxxxxxx; alu = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    check_eq("x_opc_count", wr_count, mcount);
    ra = 5'd9; #1;
    check_eq("x_opc_reg9", rd_a, 32'h0909_0909);

    // asynchronous reset mid-cycle, with a write whose edge lands inside reset
    @(negedge clk); #2;
    opc = 6'h00; wr_en = 1'b0; ra = 5'd5; rb = 5'd7;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_count", wr_count, 32'h0);
    check_eq("async_rst_a", rd_a, 32'h0);
    check_eq("async_rst_b", rd_b, 32'h0);
    wr_en = 1'b1; wr_num = 5'd3; alu = 32'h3333_3333;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; ra = 5'd3; rst_n = 1'b1;
    #1;
    check_eq("rst_discard_reg3", rd_a, 32'h0);
    check_eq("rst_discard_count", wr_count, 32'h0);

    // first write after release commits on the first edge
    drive_wb(1'b1, 5'd12, 6'h00, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd12, 5'd3);
    drain();

    // counter wrap from all-ones
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    mcount = 32'hFFFF_FFFF;
    check_eq("preload_count", wr_count, 32'hFFFF_FFFF);
    drive_wb(1'b1, 5'd13, 6'h00, 32'h1313_1313, 32'h0, 32'h0, 5'd0, 5'd13);
    check_eq("wrap_count", wr_count, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
